// File: rtl/acc_writeback.sv
// acc_writeback
//   Picks up the two accumulator entries when the accumulator reports full.
//   Each entry goes through optional ReLU, then an arithmetic right shift, then
//   saturation to a signed OUT_W-bit value. The two results are written to the
//   unified buffer one after the other over a valid/ready port.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   full                        accumulator full flag (level)
//   acc_mem_0, acc_mem_1        signed 32-bit accumulator entries
//   relu_en, shift, base_addr   per-transfer controls, sampled at capture
//   wr_valid/wr_ready           unified-buffer write handshake
//   wr_addr, wr_data            write address / signed quantized data
//   busy                        transfer in progress
//   done                        one-cycle pulse after the second write
module acc_writeback #(
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              full,
    input  logic [31:0]       acc_mem_0,
    input  logic [31:0]       acc_mem_1,
    input  logic              relu_en,
    input  logic [4:0]        shift,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [OUT_W-1:0]  wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_W - 1));

    state_t r_state;
    state_t w_state_nxt;

    logic              r_full_d;
    logic              r_armed;
    logic              r_index;
    logic [ADDR_W-1:0] r_base;
    logic [OUT_W-1:0]  r_res1;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [OUT_W-1:0]  r_wr_data;
    logic              w_trigger;
    logic              w_accept;

    function automatic logic [OUT_W-1:0] quantize(
        input logic [31:0] x,
        input logic        relu,
        input logic [4:0]  sh
    );
        logic signed [31:0] v;
        logic signed [31:0] s;
        logic [OUT_W-1:0]   r;
        v = (relu && x[31]) ? 32'sd0 : $signed(x);
        s = v >>> sh;
        if (s > SAT_MAX) begin
            r = SAT_MAX[OUT_W-1:0];
        end else if (s < SAT_MIN) begin
            r = SAT_MIN[OUT_W-1:0];
        end else begin
            r = s[OUT_W-1:0];
        end
        return r;
    endfunction

    // r_armed stays low after reset until full has been seen low, so a full
    // level that survives a reset cannot masquerade as a fresh rising edge.
    assign w_trigger = full & ~r_full_d & r_armed;
    assign w_accept  = wr_valid & wr_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_WRITE;
            S_WRITE: if (wr_ready && r_index) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        wr_valid = (r_state == S_WRITE);
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
        wr_addr  = r_wr_addr;
        wr_data  = r_wr_data;
    end

    // Edge detect and capture/write datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full_d  <= 1'b0;
            r_armed   <= 1'b0;
            r_index   <= 1'b0;
            r_base    <= '0;
            r_res1    <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_full_d <= full;
            if (!full) begin
                r_armed <= 1'b1;
            end
            if (r_state == S_WAIT) begin
                r_base    <= base_addr;
                r_res1    <= quantize(acc_mem_1, relu_en, shift);
                r_wr_addr <= base_addr;
                r_wr_data <= quantize(acc_mem_0, relu_en, shift);
                r_index   <= 1'b0;
            end else if (w_accept && !r_index) begin
                r_wr_addr <= r_base + ADDR_W'(1);
                r_wr_data <= r_res1;
                r_index   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/acc_writeback.md
Name: acc_writeback

Overview:
- Sits directly downstream of the two-entry accumulator.
- Detects the accumulator's full flag, captures both 32-bit accumulated values, and applies optional ReLU.
- Arithmetic-shifts each value right, then saturates it to a signed OUT_W-bit result.
- Writes the two results sequentially to the unified buffer over a valid/ready write port.
- Pulses done when both writes have completed.

Parameters:
- OUT_W, 8, width of the signed quantized result written to the unified buffer.
- ADDR_W, 8, unified-buffer address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- full  in  1  accumulator full flag; a level that stays high until the accumulator is reset.
- acc_mem_0  in  32  accumulator entry 0, signed two's complement.
- acc_mem_1  in  32  accumulator entry 1, signed two's complement.
- relu_en  in  1  1 = clamp negative values to 0 before shifting; sampled at capture.
- shift  in  5  arithmetic right-shift amount, 0..31; sampled at capture.
- base_addr  in  ADDR_W  destination address of entry 0; sampled at capture.
- wr_valid  out  1  write request to the unified buffer.
- wr_ready  in  1  unified buffer accepts the write this cycle.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  OUT_W  signed quantized result.
- busy  out  1  high from rising-edge detect until done.
- done  out  1  one-cycle pulse after the second write is accepted.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high and clears all state immediately.
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, state=IDLE, full_d=0, index=0, captured registers=0.
- Edge detect: full_d is a register of full, updated every cycle in every state. Trigger = full & ~full_d.
- FSM states: IDLE, WAIT, WRITE, DONE.
- IDLE -> WAIT on trigger.
- WAIT: one cycle. The accumulator's output registers lag its full flag by one cycle, so values are taken one cycle after the trigger.
  - On the WAIT clock edge, capture acc_mem_0, acc_mem_1, relu_en, shift and base_addr.
  - Compute both results. Set index=0, wr_valid=1, wr_addr=base_addr, wr_data=result0. Go to WRITE.
- WRITE: wr_valid stays high. wr_addr and wr_data are held stable until wr_valid & wr_ready.
  - On acceptance with index=0: drive wr_addr=base_addr+1 (modulo 2^ADDR_W) and wr_data=result1 on the next cycle. index=1, wr_valid stays 1.
  - On acceptance with index=1: wr_valid=0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy = 1 in WAIT, WRITE and DONE; 0 in IDLE.
- Arithmetic, per entry (signed 32-bit):
  - v = (relu_en && x<0) ? 0 : x.
  - s = v >>> shift (arithmetic shift, floor rounding).
  - result = clamp(s, -2^(OUT_W-1), 2^(OUT_W-1)-1).
- Latency: the trigger cycle is T. WAIT is cycle T+1. The first wr_valid appears at T+2. With wr_ready tied high, writes complete at T+2 and T+3 and done pulses at T+4.
- Triggers outside IDLE: ignored; full_d still tracks full. Because full is a level, one rising edge produces exactly one transfer.
- wr_ready while wr_valid=0: ignored.
- Reset mid-operation: the transfer is abandoned and no further writes are issued. If full is still high when reset is released, no trigger occurs until full falls and rises again.
- Address wrap: base_addr = 2^ADDR_W-1 writes entry 1 to address 0.

Test Plan:
- Basic, no ReLU: acc0=300, acc1=-50, relu_en=0, shift=2, base_addr=0x10, wr_ready=1.
  - Required: writes (0x10, 75) then (0x11, -13 = 0xF3). wr_valid is first seen two cycles after the full edge. done pulses once. busy drops with done.
- ReLU: same stimulus with relu_en=1.
  - Required: writes (0x10, 75) and (0x11, 0).
- Saturation: acc0=100000, acc1=-100000, shift=0, relu_en=0.
  - Required: wr_data=127 (0x7F), then -128 (0x80).
- Backpressure and wrap: base_addr=0xFF, wr_ready low for 3 cycles, high for 1, then low for 2 and high again.
  - Required: (0xFF, d0) held stable for 4 cycles. (0x00, d1) held for 3 cycles. No duplicate or dropped writes.
- Reset mid-WRITE: assert reset while wr_valid=1 and wr_ready=0, with full held high across the reset.
  - Required: all outputs 0 immediately; no write or done after reset release.
  - Then drop full, re-raise it with new values: exactly one new transfer occurs.
- Level full: hold full high for 20 cycles after a transfer.
  - Required: exactly 2 accepted writes and 1 done pulse in total.
